// File: rtl/placar.sv
// Game scoreboard: BCD score with saturation, lives, a post-hit
// invulnerability window and a sticky game-over state, plus the
// seven-segment drive for score and lives.
//
// state        | meaning
// JOGANDO      | normal play, hits and damage both count
// INVULNERAVEL | post-damage window, damage ignored, hits still score
// PERDEU       | game over, everything frozen until reset
module placar #(
    parameter int VIDAS_INICIAIS = 3,
    parameter int PONTOS_ACERTO  = 10,
    parameter int INVULN_CICLOS  = 50_000_000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        pausa,
    input  logic        acerto,
    input  logic        dano,
    output logic        perdeu,
    output logic        invulneravel,
    output logic [15:0] pontos,
    output logic [3:0]  vidas,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5
);

    localparam logic [3:0]  INC_U = 4'(PONTOS_ACERTO % 10);
    localparam logic [3:0]  INC_D = 4'(PONTOS_ACERTO / 10);
    localparam logic [31:0] CARGA = 32'(INVULN_CICLOS - 1);

    typedef enum logic [1:0] {JOGANDO, INVULNERAVEL, PERDEU} estado_t;

    estado_t     estado, estado_prox;
    logic [31:0] contador, contador_prox;
    logic [15:0] pontos_prox;
    logic [3:0]  vidas_prox;
    logic        acerto_ant, dano_ant;
    logic        ev_acerto, ev_dano;

    // Digit-serial BCD add of the per-hit increment; a carry out of the
    // thousands digit means the true sum passed 9999, so clamp there.
    function automatic logic [15:0] soma_bcd(input logic [15:0] a);
        logic [4:0]  d;
        logic [3:0]  inc;
        logic        c;
        logic [15:0] r;
        c = 1'b0;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            inc = (i == 0) ? INC_U : ((i == 1) ? INC_D : 4'd0);
            d = {1'b0, a[4*i +: 4]} + {1'b0, inc} + {4'd0, c};
            if (d > 5'd9) begin
                d = d - 5'd10;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*i +: 4] = d[3:0];
        end
        if (c) r = 16'h9999;
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign ev_acerto = acerto & ~acerto_ant;
    assign ev_dano   = dano & ~dano_ant;

    // Next-state and datapath: pause and game-over freeze everything.
    always_comb begin
        estado_prox   = estado;
        contador_prox = contador;
        pontos_prox   = pontos;
        vidas_prox    = vidas;
        if (!pausa && estado != PERDEU) begin
            if (ev_acerto) pontos_prox = soma_bcd(pontos);
            case (estado)
                JOGANDO: begin
                    if (ev_dano) begin
                        vidas_prox = vidas - 4'd1;
                        if (vidas == 4'd1) begin
                            estado_prox = PERDEU;
                        end else begin
                            estado_prox   = INVULNERAVEL;
                            contador_prox = CARGA;
                        end
                    end
                end
                INVULNERAVEL: begin
                    if (contador == 32'd0) estado_prox = JOGANDO;
                    else                   contador_prox = contador - 32'd1;
                end
                default: estado_prox = JOGANDO;
            endcase
        end
    end

    // State and game registers; edge-detect history runs even when frozen.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            estado       <= JOGANDO;
            contador     <= '0;
            pontos       <= '0;
            vidas        <= 4'(VIDAS_INICIAIS);
            perdeu       <= 1'b0;
            invulneravel <= 1'b0;
            acerto_ant   <= 1'b1;
            dano_ant     <= 1'b1;
        end else begin
            estado       <= estado_prox;
            contador     <= contador_prox;
            pontos       <= pontos_prox;
            vidas        <= vidas_prox;
            perdeu       <= (estado_prox == PERDEU);
            invulneravel <= (estado_prox == INVULNERAVEL);
            acerto_ant   <= acerto;
            dano_ant     <= dano;
        end
    end

    // Display decode straight from the registers.
    always_comb begin
        HEX0 = seg7(pontos[3:0]);
        HEX1 = seg7(pontos[7:4]);
        HEX2 = seg7(pontos[11:8]);
        HEX3 = seg7(pontos[15:12]);
        HEX4 = 7'h7F;
        HEX5 = seg7(vidas);
    end

endmodule

// File: tb/tb_placar.sv
// Bench for placar: a behavioural game model (binary score, clamped)
// predicts each cycle's outputs into a queue that is drained after the edge.
module tb_placar;

    logic        clk = 1'b0;
    logic        r_reset, r_pausa, r_acerto, r_dano;
    logic        perdeu, invulneravel;
    logic [15:0] pontos;
    logic [3:0]  vidas;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    int checks = 0;
    int failures = 0;
    int n_inv = 0;

    typedef struct {
        logic [15:0] pontos;
        logic [3:0]  vidas;
        logic        perdeu;
        logic        inv;
    } saida_t;

    saida_t fila[$];

    int m_pontos, m_vidas, m_estado, m_cont;
    bit m_pa, m_pd;

    placar #(.VIDAS_INICIAIS(3), .PONTOS_ACERTO(10), .INVULN_CICLOS(8)) dut (
        .CLOCK_50(clk), .reset(r_reset), .pausa(r_pausa),
        .acerto(r_acerto), .dano(r_dano),
        .perdeu(perdeu), .invulneravel(invulneravel),
        .pontos(pontos), .vidas(vidas),
        .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3),
        .HEX4(hex4), .HEX5(hex5)
    );

    always #5 clk = ~clk;

    task automatic verifica(input string tag, input int obs, input int esp);
        checks++;
        if (obs != esp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, obs, esp, $time);
        end
    endtask

    function automatic logic [15:0] para_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic ciclo();
        saida_t e;
        bit ea, ed;
        @(posedge clk);
        if (!r_reset) begin
            m_estado = 0; m_pontos = 0; m_vidas = 3; m_cont = 0;
            m_pa = 1'b1; m_pd = 1'b1;
        end else begin
            ea = r_acerto && !m_pa;
            ed = r_dano && !m_pd;
            m_pa = r_acerto;
            m_pd = r_dano;
            if (!r_pausa && m_estado != 2) begin
                if (ea) m_pontos = (m_pontos + 10 > 9999) ? 9999 : m_pontos + 10;
                if (m_estado == 0) begin
                    if (ed) begin
                        m_vidas--;
                        if (m_vidas == 0) m_estado = 2;
                        else begin m_estado = 1; m_cont = 7; end
                    end
                end else if (m_cont == 0) m_estado = 0;
                else m_cont--;
            end
        end
        e.pontos = para_bcd(m_pontos);
        e.vidas  = 4'(m_vidas);
        e.perdeu = (m_estado == 2);
        e.inv    = (m_estado == 1);
        fila.push_back(e);
        #1;
        if (fila.size() == 0) begin
            verifica("fila_vazia", 1, 0);
        end else begin
            e = fila.pop_front();
            verifica("pontos", int'(pontos), int'(e.pontos));
            verifica("vidas", int'(vidas), int'(e.vidas));
            verifica("perdeu", int'(perdeu), int'(e.perdeu));
            verifica("invulneravel", int'(invulneravel), int'(e.inv));
        end
        if (invulneravel) n_inv++;
    endtask

    task automatic pulso(input logic a, input logic d);
        r_acerto = a; r_dano = d;
        ciclo();
        r_acerto = 1'b0; r_dano = 1'b0;
        ciclo();
    endtask

    initial begin
        r_reset = 1'b0; r_pausa = 1'b0; r_acerto = 1'b1; r_dano = 1'b1;
        repeat (3) ciclo();
        verifica("hex4_branco", int'(hex4), 'h7F);
        verifica("hex5_reset", int'(hex5), 'h30);

        // inputs held high across reset release must not count
        r_reset = 1'b1;
        repeat (5) ciclo();
        verifica("sem_evento_pos_reset", int'(pontos), 'h0000);
        verifica("vidas_pos_reset", int'(vidas), 3);
        r_acerto = 1'b0; r_dano = 1'b0;
        ciclo();

        repeat (3) pulso(1'b1, 1'b0);
        verifica("tres_acertos", int'(pontos), 'h0030);
        verifica("hex1_3", int'(hex1), 'h30);
        verifica("hex0_0", int'(hex0), 'h40);
        verifica("hex2_0", int'(hex2), 'h40);
        verifica("hex5_3vidas", int'(hex5), 'h30);

        r_acerto = 1'b1;
        repeat (100) ciclo();
        r_acerto = 1'b0;
        ciclo();
        verifica("acerto_mantido", int'(pontos), 'h0040);

        n_inv = 0;
        pulso(1'b0, 1'b1);
        ciclo();
        pulso(1'b0, 1'b1);
        repeat (10) ciclo();
        verifica("vidas_um_dano", int'(vidas), 2);
        verifica("janela_8", n_inv, 8);

        n_inv = 0;
        pulso(1'b0, 1'b1);
        ciclo();
        r_pausa = 1'b1;
        repeat (10) ciclo();
        pulso(1'b1, 1'b0);
        repeat (8) ciclo();
        r_pausa = 1'b0;
        repeat (15) ciclo();
        verifica("janela_pausada", n_inv, 28);
        verifica("pontos_pausa", int'(pontos), 'h0040);
        verifica("vidas_1", int'(vidas), 1);

        pulso(1'b1, 1'b1);
        verifica("simult_pontos", int'(pontos), 'h0050);
        verifica("simult_vidas", int'(vidas), 0);
        verifica("simult_perdeu", int'(perdeu), 1);
        pulso(1'b1, 1'b0);
        pulso(1'b0, 1'b1);
        verifica("perdeu_congelado", int'(pontos), 'h0050);
        verifica("perdeu_mantido", int'(perdeu), 1);

        r_pausa = 1'b1; r_reset = 1'b0;
        ciclo();
        verifica("reset_em_perdeu", int'(perdeu), 0);
        verifica("reset_vidas", int'(vidas), 3);
        r_reset = 1'b1; r_pausa = 1'b0;
        ciclo();

        pulso(1'b0, 1'b1);
        r_reset = 1'b0;
        ciclo();
        verifica("reset_meio_janela", int'(invulneravel), 0);
        r_reset = 1'b1;
        ciclo();

        repeat (999) pulso(1'b1, 1'b0);
        verifica("pontos_9990", int'(pontos), 'h9990);
        verifica("hex3_9", int'(hex3), 'h10);
        verifica("hex0_0b", int'(hex0), 'h40);
        pulso(1'b1, 1'b0);
        verifica("saturacao", int'(pontos), 'h9999);
        pulso(1'b1, 1'b0);
        verifica("saturacao_mantida", int'(pontos), 'h9999);
        verifica("hex0_9", int'(hex0), 'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/placar.md
PLACAR -- requirements
Module: placar

Interface
REQ-001 Parameter VIDAS_INICIAIS, default 3, lives loaded at reset, legal range 1..9.
REQ-002 Parameter PONTOS_ACERTO, default 10, points added per enemy hit, legal range 1..99.
REQ-003 Parameter INVULN_CICLOS, default 50_000_000, invulnerability window length in clock cycles, legal range at least 1.
REQ-004 CLOCK_50  in  1  system clock; the block SHALL use this single clock for all logic.
REQ-005 reset  in  1  synchronous reset, active-low (0 = reset).
REQ-006 pausa  in  1  level; 1 freezes game state.
REQ-007 acerto  in  1  level from entities; ally ball overlaps a live enemy.
REQ-008 dano  in  1  level from entities; enemy ball overlaps the ship.
REQ-009 perdeu  out  1  game over; feeds the tela input of the same name.
REQ-010 invulneravel  out  1  1 while the invulnerability window is active.
REQ-011 pontos  out  16  score as four BCD digits, [15:12] thousands.
REQ-012 vidas  out  4  remaining lives, binary.
REQ-013 HEX0..HEX3  out  7 each  score digits, HEX0 units, active-low segments, bit6 = g.
REQ-014 HEX4  out  7  always blank (7'h7F).
REQ-015 HEX5  out  7  lives digit.

Function
REQ-016 Each of acerto and dano SHALL pass through an edge detector with a previous-sample register; an event is the cycle the input is sampled 1 after being sampled 0.
REQ-017 The previous-sample registers SHALL update every cycle, including during pausa and in PERDEU.
REQ-018 The block SHALL implement states JOGANDO, INVULNERAVEL and PERDEU.
REQ-019 In JOGANDO, a dano event SHALL decrement vidas. If vidas becomes 0, the next state SHALL be PERDEU; otherwise it SHALL be INVULNERAVEL with the window counter loaded to INVULN_CICLOS-1.
REQ-020 In INVULNERAVEL, dano events SHALL be ignored and the counter SHALL decrement each unpaused cycle. When the counter is 0 the state SHALL return to JOGANDO on that edge.
REQ-021 An acerto event in JOGANDO or INVULNERAVEL SHALL add PONTOS_ACERTO to pontos using decimal BCD add with carry between digits.
REQ-022 pontos SHALL saturate at 9999; any sum above 9999 SHALL yield exactly 9999.
REQ-023 When acerto and dano events fall in the same cycle, both SHALL apply on the same edge, including the edge that enters PERDEU.
REQ-024 In PERDEU, all events SHALL be ignored and pontos and vidas SHALL hold. The block SHALL leave PERDEU only by reset.
REQ-025 While pausa=1, events SHALL be discarded (not queued) and the state, counter, pontos and vidas SHALL hold.
REQ-026 State, counter, pontos and vidas SHALL update on the same edge that samples the event. HEX outputs SHALL be combinational from the registers, so there is zero added latency.
REQ-027 Digit segment codes SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
REQ-028 perdeu SHALL equal (state==PERDEU), and invulneravel SHALL equal (state==INVULNERAVEL); both SHALL be registered.

Reset
REQ-029 On an edge with reset=0, the block SHALL set: state JOGANDO, pontos 0000, vidas VIDAS_INICIAIS, counter 0, perdeu 0, invulneravel 0.
REQ-030 Reset SHALL load both previous-sample registers with 1, so an input held high through reset release SHALL NOT count as an event.
REQ-031 Reset SHALL take priority over pausa and over all events, including in mid-window and in PERDEU.

Verification
REQ-032 Scenario: after reset, pulse acerto 1 cycle, three times. Required: pontos=0030; HEX1=30, HEX0=40, HEX5=30.
REQ-033 Scenario: hold acerto high 100 cycles. Required: exactly one +10.
REQ-034 Scenario: with INVULN_CICLOS=8, pulse dano, then pulse dano again at cycle +3. Required: vidas 3->2; second pulse ignored; invulneravel high for exactly 8 cycles.
REQ-035 Scenario: pontos=9995, PONTOS_ACERTO=10, pulse acerto. Required: pontos=9999. A further acerto SHALL leave pontos at 9999.
REQ-036 Scenario: vidas=1, acerto and dano pulsed in the same cycle. Required: pontos +10, vidas=0, perdeu=1 on that edge; later events ignored.
REQ-037 Scenario: in INVULNERAVEL, set pausa=1 for 20 cycles and pulse acerto during the pause. Required: counter frozen, no score change; after pausa drops, the window resumes and completes with its remaining count.
